// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the RV32I fetch/decode front end.
//   - RV32I major opcodes
//   - input_type_e: instruction class reported to execute
//   - ALU operation codes (R-type and OP-IMM share one encoding)
//   - dec_bundle_t: the registered micro-op handed to execute
package rv_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    IT_R       = 4'd0,
    IT_I       = 4'd1,
    IT_L       = 4'd2,
    IT_S       = 4'd3,
    IT_B       = 4'd4,
    IT_JALR    = 4'd5,
    IT_JAL     = 4'd6,
    IT_AUIPC   = 4'd7,
    IT_LUI     = 4'd8,
    IT_ILLEGAL = 4'd9
  } input_type_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef struct packed {
    logic [31:0] pc;
    input_type_e input_type;
    logic [3:0]  alu_control;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        rd_write;
    logic        illegal;
  } dec_bundle_t;

  // alt selects SUB for funct3=0 and SRA for funct3=5; callers only raise it
  // where that alternative is architecturally meaningful.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_fetch_decode_if.sv
// rv_fetch_decode_if: instruction-memory fetch port, redirect port and the
// decoded-bundle handshake of the front end.
//   master : the fetch/decode unit
//   slave  : instruction memory + execute stage
interface rv_fetch_decode_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] instruction_addr;
  logic            instruction_req;
  logic [31:0]     instruction_read;
  logic            instruction_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_pc;
  logic [3:0]      dec_input_type;
  logic [3:0]      dec_alu_control;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [4:0]      dec_rd;
  logic [XLEN-1:0] dec_imm;
  logic            dec_rd_write;
  logic            dec_illegal;

  modport master (
    output instruction_addr, instruction_req,
    input  instruction_read, instruction_ready,
    input  redirect_valid, redirect_pc,
    output dec_valid,
    input  dec_ready,
    output dec_pc, dec_input_type, dec_alu_control, dec_rs1, dec_rs2, dec_rd,
    output dec_imm, dec_rd_write, dec_illegal
  );

  modport slave (
    input  instruction_addr, instruction_req,
    output instruction_read, instruction_ready,
    output redirect_valid, redirect_pc,
    input  dec_valid,
    output dec_ready,
    input  dec_pc, dec_input_type, dec_alu_control, dec_rs1, dec_rs2, dec_rd,
    input  dec_imm, dec_rd_write, dec_illegal
  );
endinterface

// File: rtl/rv_instr_decoder.sv
// rv_instr_decoder: combinational RV32I decoder.
//   instr  in  32-bit instruction word
//   bundle out decoded micro-op; pc field is always 0 (the caller supplies it)
// Illegal encodings collapse to an all-zero bundle with type ILLEGAL and the
// illegal flag set.
module rv_instr_decoder
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  output dec_bundle_t bundle
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic        legal;
  logic        writes_rd;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};

  always_comb begin
    bundle    = '0;
    legal     = 1'b1;
    writes_rd = 1'b0;
    case (opcode)
      OP_R: begin
        bundle.input_type  = IT_R;
        bundle.rs1         = instr[19:15];
        bundle.rs2         = instr[24:20];
        bundle.rd          = instr[11:7];
        bundle.alu_control = alu_from_funct3(f3, f7[5]);
        writes_rd          = 1'b1;
        legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      end
      OP_I: begin
        bundle.input_type  = IT_I;
        bundle.rs1         = instr[19:15];
        bundle.rd          = instr[11:7];
        bundle.imm         = imm_i;
        // funct7 only carries meaning for the shift-immediates; no SUBI exists.
        bundle.alu_control = alu_from_funct3(f3, (f3 == 3'd5) && f7[5]);
        writes_rd          = 1'b1;
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
      end
      OP_L: begin
        bundle.input_type  = IT_L;
        bundle.rs1         = instr[19:15];
        bundle.rd          = instr[11:7];
        bundle.imm         = imm_i;
        bundle.alu_control = {1'b0, f3};
        writes_rd          = 1'b1;
        legal = !((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
      end
      OP_S: begin
        bundle.input_type  = IT_S;
        bundle.rs1         = instr[19:15];
        bundle.rs2         = instr[24:20];
        bundle.imm         = imm_s;
        bundle.alu_control = {1'b0, f3};
        legal = (f3 <= 3'd2);
      end
      OP_B: begin
        bundle.input_type  = IT_B;
        bundle.rs1         = instr[19:15];
        bundle.rs2         = instr[24:20];
        bundle.imm         = imm_b;
        bundle.alu_control = {1'b0, f3};
        legal = !((f3 == 3'd2) || (f3 == 3'd3));
      end
      OP_JALR: begin
        bundle.input_type = IT_JALR;
        bundle.rs1        = instr[19:15];
        bundle.rd         = instr[11:7];
        bundle.imm        = imm_i;
        writes_rd         = 1'b1;
        legal = (f3 == 3'd0);
      end
      OP_JAL: begin
        bundle.input_type = IT_JAL;
        bundle.rd         = instr[11:7];
        bundle.imm        = imm_j;
        writes_rd         = 1'b1;
      end
      OP_AUIPC: begin
        bundle.input_type = IT_AUIPC;
        bundle.rd         = instr[11:7];
        bundle.imm        = imm_u;
        writes_rd         = 1'b1;
      end
      OP_LUI: begin
        bundle.input_type = IT_LUI;
        bundle.rd         = instr[11:7];
        bundle.imm        = imm_u;
        writes_rd         = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // Writes to x0 are architecturally discarded, so never request them.
    bundle.rd_write = writes_rd && (instr[11:7] != 5'd0);

    if (!legal) begin
      bundle            = '0;
      bundle.input_type = IT_ILLEGAL;
      bundle.illegal    = 1'b1;
    end
  end

endmodule

// File: rtl/rv_fetch_decode.sv
// rv_fetch_decode: RV32I fetch/decode front end.
//   clk, reset : clock and synchronous active-high reset
//   bus        : rv_fetch_decode_if.master
//     instruction_addr/req/read/ready : fetch port (addr is the current PC)
//     redirect_valid/redirect_pc      : control-flow redirect from execute
//     dec_valid/dec_ready + dec_*     : registered decoded bundle to execute
// Fetched words go into an IQ_DEPTH-entry circular queue; the head is decoded
// and loaded into the output register whenever that register is free or
// being consumed. A redirect flushes the queue and the output register.
module rv_fetch_decode
  import rv_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int          IQ_DEPTH     = 2
) (
  input  logic             clk,
  input  logic             reset,
  rv_fetch_decode_if.master bus
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("rv_fetch_decode: only XLEN=32 is supported");
  end
  if ((IQ_DEPTH < 2) || ((IQ_DEPTH & (IQ_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("rv_fetch_decode: IQ_DEPTH must be a power of two >= 2");
  end

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             dec_valid_q, dec_valid_d;
  dec_bundle_t      dec_q, dec_d;

  logic [XLEN-1:0]  iq_pc_q    [IQ_DEPTH];
  logic [31:0]      iq_instr_q [IQ_DEPTH];

  logic             fetch_req;
  logic             push;
  logic             pop;
  dec_bundle_t      head_dec;

  rv_instr_decoder u_decoder (
    .instr  (iq_instr_q[rd_ptr_q]),
    .bundle (head_dec)
  );

  always_comb begin
    // Request uses registered occupancy only, so a full queue never pushes
    // even when the head is popped in the same cycle.
    fetch_req   = (count_q < CNT_W'(IQ_DEPTH)) && !bus.redirect_valid;
    push        = fetch_req && bus.instruction_ready;
    pop         = (count_q != '0) && (!dec_valid_q || bus.dec_ready) && !bus.redirect_valid;

    pc_d        = pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    dec_valid_d = dec_valid_q;
    dec_d       = dec_q;

    if (bus.redirect_valid) begin
      pc_d        = bus.redirect_pc & ~XLEN'(3);
      count_d     = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      dec_valid_d = 1'b0;
    end else begin
      if (push) begin
        pc_d     = pc_q + XLEN'(4);
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        dec_d       = head_dec;
        dec_d.pc    = iq_pc_q[rd_ptr_q];
        dec_valid_d = 1'b1;
      end else if (bus.dec_ready) begin
        dec_valid_d = 1'b0;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---- fetch / queue / decode register boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_VECTOR;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      dec_valid_q <= 1'b0;
      dec_q       <= '0;
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      dec_valid_q <= dec_valid_d;
      dec_q       <= dec_d;
    end
  end

  // Queue storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      iq_pc_q[wr_ptr_q]    <= pc_q;
      iq_instr_q[wr_ptr_q] <= bus.instruction_read;
    end
  end

  assign bus.instruction_addr = pc_q;
  assign bus.instruction_req  = fetch_req;
  assign bus.dec_valid        = dec_valid_q;
  assign bus.dec_pc           = dec_q.pc;
  assign bus.dec_input_type   = dec_q.input_type;
  assign bus.dec_alu_control  = dec_q.alu_control;
  assign bus.dec_rs1          = dec_q.rs1;
  assign bus.dec_rs2          = dec_q.rs2;
  assign bus.dec_rd           = dec_q.rd;
  assign bus.dec_imm          = dec_q.imm;
  assign bus.dec_rd_write     = dec_q.rd_write;
  assign bus.dec_illegal      = dec_q.illegal;

endmodule

// File: tb/tb_rv_fetch_decode.sv
// Self-checking bench for rv_fetch_decode: directed scenarios followed by a
// randomized run, all checked against a transaction-level reference model.
module tb_rv_fetch_decode;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'h0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv_fetch_decode_if #(.XLEN(32)) bus ();

  rv_fetch_decode #(.XLEN(32), .RESET_VECTOR(RV), .IQ_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory: 64 words, aliased over the address space.
  logic [31:0] mem [64];
  assign bus.instruction_read = mem[bus.instruction_addr[7:2]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    logic signed [31:0] t;
    t = v << (32 - n);
    return t >>> (32 - n);
  endfunction

  function automatic logic [3:0] alu_of(input int f3, input bit alt);
    int base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    return 4'(base[f3] + (alt ? 1 : 0));
  endfunction

  function automatic void ref_decode(input logic [31:0] w,
      output logic [3:0] ty, output logic [3:0] alu,
      output logic [4:0] rs1, output logic [4:0] rs2, output logic [4:0] rd,
      output logic [31:0] imm, output logic wr, output logic ill);
    int op, f3, f7;
    bit u1, u2, ud;
    op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    u1 = 0; u2 = 0; ud = 0; ty = 9; alu = 0; imm = 0; ill = 0;
    case (op)
      'h33: begin
        ty = 0; u1 = 1; u2 = 1; ud = 1;
        if (f7 == 0) alu = alu_of(f3, 0);
        else if (f7 == 'h20 && (f3 == 0 || f3 == 5)) alu = alu_of(f3, 1);
        else ill = 1;
      end
      'h13: begin
        ty = 1; u1 = 1; ud = 1; imm = sext({20'b0, w[31:20]}, 12);
        if (f3 == 1) ill = (f7 != 0);
        if (f3 == 5) ill = !(f7 == 0 || f7 == 'h20);
        alu = alu_of(f3, f3 == 5 && f7 == 'h20);
      end
      'h03: begin
        ty = 2; u1 = 1; ud = 1; imm = sext({20'b0, w[31:20]}, 12);
        alu = 4'(f3); ill = (f3 == 3 || f3 == 6 || f3 == 7);
      end
      'h23: begin
        ty = 3; u1 = 1; u2 = 1; imm = sext({20'b0, w[31:25], w[11:7]}, 12);
        alu = 4'(f3); ill = (f3 > 2);
      end
      'h63: begin
        ty = 4; u1 = 1; u2 = 1;
        imm = sext({19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
        alu = 4'(f3); ill = (f3 == 2 || f3 == 3);
      end
      'h67: begin
        ty = 5; u1 = 1; ud = 1; imm = sext({20'b0, w[31:20]}, 12); ill = (f3 != 0);
      end
      'h6f: begin
        ty = 6; ud = 1; imm = sext({11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
      end
      'h17: begin ty = 7; ud = 1; imm = w & 32'hFFFFF000; end
      'h37: begin ty = 8; ud = 1; imm = w & 32'hFFFFF000; end
      default: ill = 1;
    endcase
    rs1 = u1 ? w[19:15] : 5'd0;
    rs2 = u2 ? w[24:20] : 5'd0;
    rd  = ud ? w[11:7]  : 5'd0;
    wr  = ud && (w[11:7] != 0);
    if (ill) begin
      ty = 9; alu = 0; rs1 = 0; rs2 = 0; rd = 0; imm = 0; wr = 0;
    end
  endfunction

  // Model state: PC, queue of fetched PCs, and the held output bundle.
  logic [31:0] m_pc;
  logic [31:0] m_q [$];
  bit          m_dv, m_zero, m_known;
  logic [31:0] m_dpc, m_dword;

  // Snapshot of DUT outputs taken each cycle for directed checks.
  logic [31:0] s_addr, s_pc, s_imm;
  logic        s_req, s_dv, s_wr, s_ill;
  logic [3:0]  s_ty, s_alu;
  logic [4:0]  s_rs1, s_rs2, s_rd;

  // One clock: sample at negedge+1, check against model, advance the model
  // with the inputs currently applied, then move to the next negedge.
  task automatic step();
    logic [3:0]  ety, ealu;
    logic [4:0]  e1, e2, ed;
    logic [31:0] eimm, fpc;
    logic        ewr, eill;
    bit          pop, fire;
    #1;
    s_addr = bus.instruction_addr; s_req = bus.instruction_req; s_dv = bus.dec_valid;
    s_pc = bus.dec_pc; s_ty = bus.dec_input_type; s_alu = bus.dec_alu_control;
    s_rs1 = bus.dec_rs1; s_rs2 = bus.dec_rs2; s_rd = bus.dec_rd; s_imm = bus.dec_imm;
    s_wr = bus.dec_rd_write; s_ill = bus.dec_illegal;
    if (m_known) begin
      check("instruction_addr", s_addr, m_pc);
      check("instruction_req", 32'(s_req), 32'((m_q.size() < DEPTH) && !bus.redirect_valid));
      check("dec_valid", 32'(s_dv), 32'(m_dv));
      if (m_dv || m_zero) begin
        if (m_zero) begin
          ety = 0; ealu = 0; e1 = 0; e2 = 0; ed = 0; eimm = 0; ewr = 0; eill = 0;
        end else begin
          ref_decode(m_dword, ety, ealu, e1, e2, ed, eimm, ewr, eill);
        end
        check("dec_pc", s_pc, m_zero ? 32'h0 : m_dpc);
        check("dec_input_type", 32'(s_ty), 32'(ety));
        check("dec_alu_control", 32'(s_alu), 32'(ealu));
        check("dec_rs1", 32'(s_rs1), 32'(e1));
        check("dec_rs2", 32'(s_rs2), 32'(e2));
        check("dec_rd", 32'(s_rd), 32'(ed));
        check("dec_imm", s_imm, eimm);
        check("dec_rd_write", 32'(s_wr), 32'(ewr));
        check("dec_illegal", 32'(s_ill), 32'(eill));
      end
    end
    if (reset) begin
      m_pc = RV; m_q.delete(); m_dv = 0; m_zero = 1; m_known = 1;
    end else if (m_known) begin
      if (bus.redirect_valid) begin
        m_pc = {bus.redirect_pc[31:2], 2'b00}; m_q.delete(); m_dv = 0;
      end else begin
        pop  = (m_q.size() > 0) && (!m_dv || bus.dec_ready);
        fire = (m_q.size() < DEPTH) && bus.instruction_ready;
        fpc  = m_pc;
        if (pop) begin
          m_dpc = m_q.pop_front(); m_dword = mem[m_dpc[7:2]]; m_dv = 1; m_zero = 0;
        end else if (bus.dec_ready) begin
          m_dv = 0;
        end
        if (fire) begin
          m_q.push_back(fpc); m_pc = fpc + 32'd4;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input bit rdy, input bit drdy);
    reset = 1; bus.redirect_valid = 0; bus.redirect_pc = 0;
    bus.instruction_ready = rdy; bus.dec_ready = drdy;
    step();
    reset = 0;
  endtask

  logic [31:0] got [$];
  logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6f, 7'h17, 7'h37};

  initial begin
    int fires;
    bit found;
    logic [31:0] w;
    m_known = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h00940333;
    do_reset(1, 1);

    // Streaming: addresses step by 4, first bundle two cycles after first fetch.
    for (int c = 0; c < 4; c++) begin
      step();
      if (c < 3) check("stream_addr", s_addr, 32'(4 * c));
      if (c < 2) check("stream_early_valid", 32'(s_dv), 0);
      if (c == 2) begin
        check("stream_first_valid", 32'(s_dv), 1);
        check("stream_pc", s_pc, 0);
        check("stream_type", 32'(s_ty), 0);
        check("stream_alu", 32'(s_alu), 0);
        check("stream_rs1", 32'(s_rs1), 8);
        check("stream_rs2", 32'(s_rs2), 9);
        check("stream_rd", 32'(s_rd), 6);
        check("stream_rd_write", 32'(s_wr), 1);
      end
    end

    // Backpressure from reset: exactly three fetches accepted.
    do_reset(1, 0);
    fires = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (s_req && bus.instruction_ready) fires++;
    end
    check("bp_fetch_count", 32'(fires), 3);
    check("bp_req_stalled", 32'(s_req), 0);
    check("bp_addr_hold", s_addr, 32'hC);
    bus.dec_ready = 1;
    got.delete();
    for (int c = 0; c < 8; c++) begin
      step();
      if (s_dv) got.push_back(s_pc);
    end
    check("bp_drain_len_ok", 32'(got.size() >= 4), 1);
    for (int k = 0; k < 4; k++)
      if (k < got.size()) check("bp_drain_pc", got[k], 32'(4 * k));

    // Redirect with two queued entries and a held bundle.
    do_reset(1, 0);
    for (int c = 0; c < 3; c++) step();
    bus.redirect_valid = 1; bus.redirect_pc = 32'h103;
    step();
    check("rd_pre_valid", 32'(s_dv), 1);
    bus.redirect_valid = 0; bus.dec_ready = 1;
    step();
    check("rd_addr", s_addr, 32'h100);
    check("rd_valid_cleared", 32'(s_dv), 0);
    got.delete();
    for (int c = 0; c < 10; c++) begin
      step();
      if (s_dv) got.push_back(s_pc);
    end
    found = (got.size() >= 2);
    check("rd_bundles_seen", 32'(found), 1);
    if (found) begin
      check("rd_first_pc", got[0], 32'h100);
      check("rd_second_pc", got[1], 32'h104);
    end

    // Immediates and illegal encodings.
    mem[0] = 32'h00c702a3; mem[1] = 32'hffdff06f; mem[2] = 32'h400a5393;
    mem[3] = 32'h02000033; mem[4] = 32'h0000007f; mem[5] = 32'h00940333;
    do_reset(1, 1);
    for (int c = 0; c < 9; c++) begin
      step();
      if (s_dv) begin
        case (s_pc)
          32'h0: begin
            check("sw_type", 32'(s_ty), 3); check("sw_alu", 32'(s_alu), 0);
            check("sw_imm", s_imm, 5); check("sw_rs1", 32'(s_rs1), 14);
            check("sw_rs2", 32'(s_rs2), 12); check("sw_rd_write", 32'(s_wr), 0);
          end
          32'h4: begin
            check("jal_type", 32'(s_ty), 6); check("jal_imm", s_imm, 32'hFFFFFFFC);
            check("jal_rd_write", 32'(s_wr), 0);
          end
          32'h8: begin
            check("srai_type", 32'(s_ty), 1); check("srai_alu", 32'(s_alu), 7);
          end
          32'hC: begin
            check("mul_illegal", 32'(s_ill), 1); check("mul_type", 32'(s_ty), 9);
            check("mul_rd_write", 32'(s_wr), 0);
          end
          32'h10: check("op7f_illegal", 32'(s_ill), 1);
          32'h14: begin
            check("legal_after_illegal", 32'(s_ill), 0); check("legal_type", 32'(s_ty), 0);
            check("legal_rd_write", 32'(s_wr), 1);
          end
          default: ;
        endcase
      end
    end

    // Reset mid-stream with a full queue and a stalled bundle.
    for (int i = 0; i < 64; i++) mem[i] = 32'h00940333;
    do_reset(1, 0);
    for (int c = 0; c < 5; c++) step();
    check("mr_full", 32'(s_req), 0);
    reset = 1;
    step();
    reset = 0;
    step();
    check("mr_addr", s_addr, RV);
    check("mr_valid", 32'(s_dv), 0);
    check("mr_req_empty", 32'(s_req), 1);

    // Randomized run.
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if ($urandom_range(0, 9) != 0) begin
        w[6:0] = ops[$urandom_range(0, 8)];
        if ($urandom_range(0, 1) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      mem[i] = w;
    end
    do_reset(1, 1);
    for (int c = 0; c < 3000; c++) begin
      reset                 = ($urandom_range(0, 199) == 0);
      bus.redirect_valid    = ($urandom_range(0, 24) == 0);
      bus.redirect_pc       = $urandom;
      bus.instruction_ready = ($urandom_range(0, 3) != 0);
      bus.dec_ready         = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
